// File: rtl/adc_defs_pkg.sv
// adc_defs: shared definitions for the ADC capture path.
//   DATA_W_DEF     default ADC sample width
//   CLK_DIV_DEF    default system clocks per ADC_CLK period
//   FIFO_DEPTH_DEF default output FIFO depth
//   clog2()        constant ceil(log2) helper for pointer/level widths
//   LEVEL_W_DEF    LEVEL width for the default FIFO depth
package adc_defs;

  localparam int DATA_W_DEF     = 8;
  localparam int CLK_DIV_DEF    = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  localparam int LEVEL_W_DEF = clog2(FIFO_DEPTH_DEF) + 1;

endpackage

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: show-ahead FIFO with registered head data and valid.
//   clk, rst    system clock, asynchronous active-high reset
//   push        write push_data (accepted when not full, or full with a pop)
//   push_data   entry to write
//   pop         consume the current head (ignored when empty)
//   head        current head entry, holds its last value when empty
//   valid       FIFO non-empty (registered)
//   full/empty  occupancy flags
//   level       occupancy 0..DEPTH
module adc_sample_fifo
  import adc_defs::*;
#(
  parameter int WIDTH = DATA_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic                    valid,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level
);

  localparam int PTR_W   = clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_ptr_nxt;
  logic [LEVEL_W-1:0] count;
  logic [LEVEL_W-1:0] count_after_pop;
  logic [LEVEL_W-1:0] count_nxt;
  logic               do_push;
  logic               do_pop;
  logic [WIDTH-1:0]   head_nxt;

  assign empty = (count == '0);
  assign full  = (count == LEVEL_W'(DEPTH));
  assign level = count;

  // A full FIFO still accepts a push when the head is popped in the same
  // cycle. The next head comes from storage unless the FIFO would be empty
  // after the pop, in which case the incoming entry becomes the head.
  always_comb begin
    do_pop          = pop && !empty;
    do_push         = push && (!full || do_pop);
    count_after_pop = count - LEVEL_W'(do_pop);
    count_nxt       = count_after_pop + LEVEL_W'(do_push);
    rd_ptr_nxt      = rd_ptr + PTR_W'(do_pop);
    head_nxt        = head;
    if (count_after_pop != '0) begin
      head_nxt = mem[rd_ptr_nxt];
    end else if (do_push) begin
      head_nxt = push_data;
    end
  end

  // Storage needs no reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      head   <= head_nxt;
      valid  <= (count_nxt != '0);
    end
  end

endmodule

// File: rtl/adc_capture.sv
// adc_capture: ADC sample clock generation, parallel capture, power-of-two
// averaging and a show-ahead output FIFO with valid/ready handshake.
//   CLK, RESET     system clock, asynchronous active-high reset
//   ENABLE         run capture; low idles the divider and drops partial sums
//   TEST_MODE      (only with ADC_CAPTURE_TEST_PATTERN_EN) capture a ramp
//   ADC_CLK        registered ADC sample clock, high for the first half period
//   ADC            parallel unsigned ADC data
//   SAMPLE         averaged sample at the FIFO head
//   SAMPLE_VALID   FIFO non-empty
//   SAMPLE_READY   downstream consumes SAMPLE this cycle
//   OVERRUN        sticky: a result was dropped on a full FIFO
//   LEVEL          FIFO occupancy
// Optional feature macro: ADC_CAPTURE_TEST_PATTERN_EN
module adc_capture
  import adc_defs::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLK_DIV      = CLK_DIV_DEF,
  parameter int SAMPLE_PHASE = 1,
  parameter int AVG_LOG2     = 2,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        ENABLE,
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
  input  logic                        TEST_MODE,
`endif
  output logic                        ADC_CLK,
  input  logic [DATA_W-1:0]           ADC,
  output logic [DATA_W-1:0]           SAMPLE,
  output logic                        SAMPLE_VALID,
  input  logic                        SAMPLE_READY,
  output logic                        OVERRUN,
  output logic [clog2(FIFO_DEPTH):0]  LEVEL
);

  localparam int PHASE_W = clog2(CLK_DIV);
  localparam int ACC_W   = DATA_W + AVG_LOG2;
  localparam int CNT_W   = AVG_LOG2 + 1;
  localparam int AVG_N   = 1 << AVG_LOG2;

  logic [PHASE_W-1:0] phase;
  logic               capture_en;
  logic [DATA_W-1:0]  capture_data;
  logic [DATA_W-1:0]  adc_q;
  logic               cap_valid;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   sum;
  logic [CNT_W-1:0]   count;
  logic               group_done;
  logic               push_q;
  logic [DATA_W-1:0]  result_q;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;

  // Divider: ADC_CLK is registered from the current phase so it is high
  // for phases 0..CLK_DIV/2-1 and goes straight to 0 when disabled.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      phase   <= '0;
      ADC_CLK <= 1'b0;
    end else if (!ENABLE) begin
      phase   <= '0;
      ADC_CLK <= 1'b0;
    end else begin
      ADC_CLK <= (phase < PHASE_W'(CLK_DIV / 2));
      phase   <= (phase == PHASE_W'(CLK_DIV - 1)) ? '0 : phase + PHASE_W'(1);
    end
  end

  assign capture_en = ENABLE && (phase == PHASE_W'(SAMPLE_PHASE));

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
  logic [DATA_W-1:0] ramp;

  // Ramp advances once per capture taken in test mode, wrapping naturally
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ramp <= '0;
    end else if (capture_en && TEST_MODE) begin
      ramp <= ramp + DATA_W'(1);
    end
  end

  assign capture_data = TEST_MODE ? ramp : ADC;
`else
  assign capture_data = ADC;
`endif

  // Capture stage: cap_valid marks adc_q as fresh for the accumulator
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      adc_q     <= '0;
      cap_valid <= 1'b0;
    end else begin
      cap_valid <= capture_en;
      if (capture_en) adc_q <= capture_data;
    end
  end

  assign sum        = acc + ACC_W'(adc_q);
  assign group_done = (count == CNT_W'(AVG_N - 1));

  // Accumulate stage: the final sample of a group is folded into the
  // pushed result directly, so acc never needs to hold a full group.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      acc      <= '0;
      count    <= '0;
      push_q   <= 1'b0;
      result_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (!ENABLE) begin
        acc   <= '0;
        count <= '0;
      end else if (cap_valid) begin
        if (group_done) begin
          acc      <= '0;
          count    <= '0;
          push_q   <= 1'b1;
          result_q <= DATA_W'(sum >> AVG_LOG2);
        end else begin
          acc   <= sum;
          count <= count + CNT_W'(1);
        end
      end
    end
  end

  assign pop = SAMPLE_READY && !fifo_empty;

  // A push is only lost when the FIFO is full and nothing leaves this cycle
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      OVERRUN <= 1'b0;
    end else if (push_q && fifo_full && !pop) begin
      OVERRUN <= 1'b1;
    end
  end

  adc_sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .push      (push_q),
    .push_data (result_q),
    .pop       (pop),
    .head      (SAMPLE),
    .valid     (SAMPLE_VALID),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (LEVEL)
  );

endmodule
